uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter for the MIPS_UART system, the transmit counterpart of the receive path. Accepts a byte from the processor-side register interface on a one-cycle start strobe and shifts it out as an 8N1 frame, or 8E1 when parity is compiled in, on a single `tx` line. Generates its own bit timing from the system clock. Reports busy and done status for the memory-mapped UART status register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `DATA_BITS`, default 8: payload width.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `tx_start`  in  1: one-cycle request to send `tx_data`.
- `tx_data`  in  DATA_BITS: byte to send; sampled only in the cycle a request is accepted.
- `tx`  out  1: serial line; idles high.
- `tx_busy`  out  1: high while a frame is in progress.
- `tx_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- IDLE: `tx`=1, `tx_busy`=0. `tx_start`=1 → latch `tx_data` into the shift register, clear the bit-cycle counter and bit index, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx` = shift_reg[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After DATA_BITS bits, go to PARITY if enabled, otherwise STOP.
- PARITY: `tx` = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse `tx_done`.
- Bit-cycle counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- `tx_start` while `tx_busy`=1 is ignored: no queueing, no error flag.
- `tx_data` changes after acceptance do not affect the frame in flight.
- `tx` is driven from a register, so it carries no combinational glitches.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, counters=0, shift register=0.
- `rst` mid-frame aborts the frame. `tx` returns to 1 on the next edge, and no `tx_done` is generated.
- Cycle N: `tx_start` sampled high in IDLE. Cycle N+1: `tx`=0 and `tx_busy`=1.
- Frame length is F×CLKS_PER_BIT cycles from the first START cycle to the end of STOP. F=10 by default, F=11 with parity.
- `tx_done`=1 and `tx_busy`=0 in the first IDLE cycle after STOP. `tx` stays 1.
- `tx_start` asserted in that same cycle is accepted. Back-to-back frames have zero idle bit-time between the stop bit and the next start bit.
- `tx_start` and `rst` in the same cycle: `rst` wins and the request is dropped.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state and even-parity bit are inserted between the last data bit and the stop bit; frame is 11 bits.
  - Undefined: the PARITY state, parity logic and related encoding are absent; frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef `uart_tx_state_t`.
  - Frame constants `UART_START_BIT`=0 and `UART_STOP_BIT`=1.
  - Default baud constant used by the UART top.
- Sub-module `uart_baud_cnt`:
  - Parameterised cycle counter with `clk`, `rst` and `clr` inputs and a `bit_end` output that pulses in the last cycle of each bit.
  - `uart_tx` instantiates it and advances the FSM on `bit_end`.
  - The same counter is reusable by the receiver.
- Remaining logic (FSM, shift register, parity) lives in `uart_tx`, about 150–200 lines.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset, then idle 20 cycles → `tx`=1, `tx_busy`=0, `tx_done` never asserted.
- `tx_start` with `tx_data`=8'hA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_done` pulses exactly once, 40 cycles after the first start-bit cycle.
- `tx_start` pulses during the DATA state of frame 8'h3C, with `tx_data`=8'hFF → ignored; the serialized byte is 8'h3C and only one `tx_done` pulse occurs.
- `tx_start` with 8'h55 in the `tx_done` cycle of the previous frame → next start bit begins the following cycle; total of 80 cycles for two frames.
- `rst` asserted during bit 3 of the DATA state → next cycle `tx`=1 and `tx_busy`=0, with no `tx_done`. A new frame with 8'h01 then transmits correctly.
- With `UART_TX_PARITY_EN` defined, send 8'h07 → parity bit 1, frame length 44 cycles. Send 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame constants
// UART_TX_PARITY_EN adds the PARITY state to the transmitter FSM encoding.
package uart_pkg;

  localparam int   UART_CLKS_PER_BIT = 868;
  localparam logic UART_START_BIT    = 1'b0;
  localparam logic UART_STOP_BIT     = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period cycle counter shared by the UART paths
// Counts 0..CLKS_PER_BIT-1 while clr is low; bit_end marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int              W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0]    LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign bit_end = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with registered serial output
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int             IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);

  uart_tx_state_t       state, state_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [IW-1:0]        bit_idx, idx_n;
  logic                 tx_q, tx_n;
  logic                 busy_q, done_q, done_n;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_n;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_q      <= UART_STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_idx   <= idx_n;
      tx_q      <= tx_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    idx_n   = bit_idx;
    done_n  = 1'b0;
    tx_n    = UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_n = START;
          shift_n = tx_data;
          idx_n   = '0;
`ifdef UART_TX_PARITY_EN
          parity_n = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_idx == LAST_IDX) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is computed for the state being entered so the output register lines up with it
    case (state_n)
      START:   tx_n = UART_START_BIT;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = UART_STOP_BIT;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx at CLKS_PER_BIT=4
// Parity scenarios run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  task automatic start_frame(input logic [7:0] data);
    tx_start = 1'b1;
    tx_data  = data;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~data;
  endtask

  // exp10 is start,d0..d7,stop written first-bit-leftmost; par is the hand-computed even parity
  task automatic check_frame(input string name, input logic [9:0] exp10, input logic par,
                             input int inject_at);
    logic [10:0] e;
`ifdef UART_TX_PARITY_EN
    e = {exp10[9:1], par, exp10[0]};
`else
    e = {exp10, 1'b1};
`endif
    for (int k = 0; k < NB * CPB; k++) begin
      if (k == inject_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else begin
        tx_start = 1'b0;
      end
      if (tx_busy) busy_cycles++;
      tests++;
      if ({tx, tx_busy, tx_done} !== {e[10 - k / CPB], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL %s bit %0d cycle %0d: got tx/busy/done=%b expected %b", name,
                 k / CPB, k, {tx, tx_busy, tx_done}, {e[10 - k / CPB], 1'b1, 1'b0});
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b101) begin
      fails++;
      $display("FAIL %s done: got tx/busy/done=%b expected 101", name, {tx, tx_busy, tx_done});
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        fails++;
        $display("FAIL %s idle cycle %0d: got tx/busy/done=%b expected 100", name, i,
                 {tx, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_values: got tx/busy/done=%b expected 100", {tx, tx_busy, tx_done});
    end
    idle_check("reset_idle", 20);
    rst = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'hA5;
    @(negedge clk);
    rst = 1'b0;
    tx_start = 1'b0;
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      fails++;
      $display("FAIL rst_beats_start: got tx/busy/done=%b expected 100", {tx, tx_busy, tx_done});
    end
    idle_check("rst_beats_start_idle", 8);
  endtask

  task automatic test_single_frame();
    start_frame(8'hA5);
    check_frame("frame_a5", 10'b0101001011, 1'b0, -1);
    idle_check("frame_a5_after", 4);
  endtask

  task automatic test_ignore_start();
    start_frame(8'h3C);
    check_frame("ignore_start_3c", 10'b0001111001, 1'b0, 12);
    idle_check("ignore_start_after", 4);
    start_frame(8'h3C);
    check_frame("ignore_start_3c_b", 10'b0001111001, 1'b0, 25);
    idle_check("ignore_start_b_after", 4);
  endtask

  task automatic test_back_to_back();
    busy_cycles = 0;
    start_frame(8'hA5);
    check_frame("b2b_first", 10'b0101001011, 1'b0, -1);
    start_frame(8'h55);
    check_frame("b2b_second", 10'b0101010101, 1'b0, -1);
    tests++;
    if (busy_cycles !== 2 * NB * CPB) begin
      fails++;
      $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cycles, 2 * NB * CPB);
    end
    idle_check("b2b_after", 4);
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'hA5);
    repeat (17) @(negedge clk);
    tests++;
    if ({tx, tx_busy} !== 2'b01) begin
      fails++;
      $display("FAIL mid_rst_data_bit3: got tx/busy=%b expected 01", {tx, tx_busy});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      fails++;
      $display("FAIL mid_rst_abort: got tx/busy/done=%b expected 100", {tx, tx_busy, tx_done});
    end
    idle_check("mid_rst_no_done", 50);
    start_frame(8'h01);
    check_frame("rst_recover_01", 10'b0100000001, 1'b1, -1);
    idle_check("rst_recover_after", 2);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    start_frame(8'h07);
    check_frame("parity_07", 10'b0111000001, 1'b1, -1);
    idle_check("parity_07_after", 2);
    start_frame(8'h03);
    check_frame("parity_03", 10'b0110000001, 1'b0, -1);
    idle_check("parity_03_after", 2);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
